regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the register file write port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset; it is synchronous and active-low.
REQ-004 SHALL have ports issue_valid input 1, issue_rd/issue_rs1/issue_rs2 input 5 each, and issue_ready output 1: the issue-stage request with its destination and source registers.
REQ-005 SHALL have ports for requester i in {0 ALU, 1 MEM, 2 FPU}: req_valid[i] input 1, req_rd[i] input 5, req_data[i] input XLEN, req_ready[i] output 1.
REQ-006 SHALL have ports we3 output 1, wa3 output 5, wd3 output XLEN, driving the register file write port.
REQ-007 SHALL have port busy output 32, the scoreboard bitmap (bit n set = register n has a pending write).

Function
REQ-008 SHALL treat a requester transfer as occurring on a cycle with req_valid[i]=1 and req_ready[i]=1; requesters hold valid, rd and data stable until that cycle.
REQ-009 SHALL assert at most one req_ready per cycle, and only to a requester with req_valid=1.
REQ-010 SHALL arbitrate round-robin with a 2-bit last-grant pointer: search order starts at (last+1) mod 3; pointer updates to the granted index on each transfer; no change without a transfer.
REQ-011 SHALL produce req_ready combinationally from req_valid and the pointer in the same cycle (zero-cycle grant).
REQ-012 SHALL register the accepted transfer: transfer in cycle N -> we3=1, wa3=req_rd, wd3=req_data in cycle N+1; we3=0 in cycles following a no-transfer cycle.
REQ-013 SHALL force we3=0 for a transfer with req_rd=0; the transfer is still accepted and the pointer still advances.
REQ-014 SHALL keep busy[0]=0 at all times.
REQ-015 SHALL drive issue_ready=1 iff none of busy[issue_rs1], busy[issue_rs2], busy[issue_rd] is set (RAW and WAW stall); index 0 is never busy.
REQ-016 SHALL set busy[issue_rd] at the clock edge ending a cycle with issue_valid=1 and issue_ready=1 (issue_rd≠0).
REQ-017 SHALL clear busy[wa3] at the clock edge ending a cycle with we3=1; the register file commits wd3 on that same edge, so a dependent read is clean the next cycle.
REQ-018 SHALL give set priority when set and clear target the same register on one edge.
REQ-019 SHALL update busy only through the rules above; a requester writing a non-busy register is legal and leaves busy unchanged.
REQ-020 SHALL sustain one writeback per cycle under continuous requests, with no bubble between grants.

Reset
REQ-021 SHALL, on a cycle with rstn=0, clear busy to 0, set we3=0, wa3=0 and wd3=0, and set the pointer to 2 (requester 0 searched first).
REQ-022 SHALL force req_ready=0 and issue_ready=0 while rstn=0; a reset mid-transfer discards the transfer and any pending registered write.

Verification
REQ-023 SHALL pass: all three req_valid=1 continuously from reset, with distinct rd 5/6/7 -> grants 0,1,2,0,... on consecutive cycles; we3 pulses every cycle from the second grant cycle on, with wa3 5,6,7,5.
REQ-024 SHALL pass: issue rd=9 accepted, then issue rs1=9 -> issue_ready=0 until the cycle after MEM writes rd=9 (we3=1, wa3=9), then 1.
REQ-025 SHALL pass: issue rd=4 accepted on the same edge that we3 writes wa3=4 -> busy[4]=1 afterwards.
REQ-026 SHALL pass: ALU transfer with rd=0 and data 0xDEADBEEF -> req_ready=1, we3=0 next cycle, busy=0.
REQ-027 SHALL pass: rstn=0 for one cycle while busy=0x0000_0F00 and FPU is mid-handshake -> next cycle busy=0, we3=0, and the first grant goes to ALU.
REQ-028 SHALL pass: only FPU valid for 3 cycles with data 1, 2, 3 and rd=31 -> three grants to FPU, wd3 sequence 1, 2, 3 on consecutive cycles.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port: round-robin over ALU/MEM/FPU
// with a zero-cycle grant, a registered write port, and a busy scoreboard that stalls issue.
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic [4:0]                issue_rs1,
    input  logic [4:0]                issue_rs2,
    output logic                      issue_ready,
    input  logic [2:0]                req_valid,
    input  logic [2:0][4:0]           req_rd,
    input  logic [2:0][XLEN-1:0]      req_data,
    output logic [2:0]                req_ready,
    output logic                      we3,
    output logic [4:0]                wa3,
    output logic [XLEN-1:0]           wd3,
    output logic [31:0]               busy
);

    logic [1:0]      r_last;
    logic            r_we3;
    logic [4:0]      r_wa3;
    logic [XLEN-1:0] r_wd3;
    logic [31:0]     r_busy;

    logic            w_xfer;
    logic [1:0]      w_gidx;
    logic [1:0]      w_scan;
    logic            w_issue_fire;
    logic [31:0]     w_busy_nxt;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // First valid requester found scanning from the one after the last grant.
    always_comb begin
        w_xfer = 1'b0;
        w_gidx = 2'd0;
        w_scan = r_last;
        for (int k = 0; k < 3; k++) begin
            w_scan = nxt(w_scan);
            if (!w_xfer && req_valid[w_scan]) begin
                w_xfer = rstn;
                w_gidx = w_scan;
            end
        end
    end

    always_comb begin
        req_ready = 3'b000;
        if (w_xfer)
            req_ready[w_gidx] = 1'b1;
    end

    assign issue_ready  = rstn && !r_busy[issue_rs1] && !r_busy[issue_rs2] && !r_busy[issue_rd];
    assign w_issue_fire = issue_valid && issue_ready;

    // Clear from the committing write is applied first so a same-edge issue set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3)
            w_busy_nxt[r_wa3] = 1'b0;
        if (w_issue_fire)
            w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_last <= 2'd2;
            r_we3  <= 1'b0;
            r_wa3  <= 5'd0;
            r_wd3  <= '0;
            r_busy <= 32'd0;
        end else begin
            if (w_xfer) begin
                r_last <= w_gidx;
                r_wa3  <= req_rd[w_gidx];
                r_wd3  <= req_data[w_gidx];
            end
            r_we3  <= w_xfer && (req_rd[w_gidx] != 5'd0);
            r_busy <= w_busy_nxt;
        end
    end

    assign we3  = r_we3;
    assign wa3  = r_wa3;
    assign wd3  = r_wd3;
    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table-driven cycle vectors with expected grants,
// a writeback scoreboard queue, and hand-written scoreboard/reset corner sequences.
module tb_regfile_wb_arbiter;

    logic             clk = 1'b0;
    logic             rstn;
    logic             issue_valid;
    logic [4:0]       issue_rd, issue_rs1, issue_rs2;
    logic             issue_ready;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_rd;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_ready;
    logic             we3;
    logic [4:0]       wa3;
    logic [31:0]      wd3;
    logic [31:0]      busy;

    regfile_wb_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_ready(issue_ready),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rstn;
        logic [2:0]       vld;
        logic [2:0][4:0]  rd;
        logic [2:0][31:0] d;
        logic             iv;
        logic [4:0]       ird, irs1, irs2;
        logic [2:0]       exp_rdy;
        logic             exp_irdy;
        logic             chk_busy;
        logic [31:0]      exp_busy;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        full;
    } wb_t;

    int   tests  = 0;
    int   failed = 0;
    wb_t  sbq[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [2:0] vld,
                                input logic [4:0] rd0, rd1, rd2,
                                input logic [31:0] d0, d1, d2,
                                input logic iv, input logic [4:0] ird, irs1, irs2,
                                input logic [2:0] erdy, input logic eirdy,
                                input logic cb, input logic [31:0] eb);
        vec_t v;
        v.rstn = r; v.vld = vld;
        v.rd[0] = rd0; v.rd[1] = rd1; v.rd[2] = rd2;
        v.d[0] = d0;   v.d[1] = d1;   v.d[2] = d2;
        v.iv = iv; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
        v.exp_rdy = erdy; v.exp_irdy = eirdy; v.chk_busy = cb; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs and the writeback due this cycle,
    // then queue the writeback the expected grant should produce next cycle.
    task automatic step(input vec_t v, input string nm);
        wb_t e;
        int  g;
        @(posedge clk);
        #1;
        rstn = v.rstn; req_valid = v.vld; req_rd = v.rd; req_data = v.d;
        issue_valid = v.iv; issue_rd = v.ird; issue_rs1 = v.irs1; issue_rs2 = v.irs2;
        @(negedge clk);
        chk({nm, "_req_ready"}, {29'd0, req_ready}, {29'd0, v.exp_rdy});
        chk({nm, "_issue_ready"}, {31'd0, issue_ready}, {31'd0, v.exp_irdy});
        if (v.chk_busy)
            chk({nm, "_busy"}, busy, v.exp_busy);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({nm, "_we3"}, {31'd0, we3}, {31'd0, e.we});
            if (e.full) begin
                chk({nm, "_wa3"}, {27'd0, wa3}, {27'd0, e.wa});
                chk({nm, "_wd3"}, wd3, e.wd);
            end
        end
        g = v.exp_rdy[0] ? 0 : v.exp_rdy[1] ? 1 : 2;
        if (!v.rstn)
            sbq.push_back('{1'b0, 5'd0, 32'd0, 1'b1});
        else if (v.exp_rdy != 3'b000)
            sbq.push_back('{v.rd[g] != 5'd0, v.rd[g], v.d[g], v.rd[g] != 5'd0});
        else
            sbq.push_back('{1'b0, 5'd0, 32'd0, 1'b0});
    endtask

    initial begin
        rstn = 1'b0; req_valid = 3'b000; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;

        // Reset, then all three requesting back to back, rd=0 ALU write, FPU-only stream.
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 5, 6, 7, 'h100, 'h101, 'h102, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        tbl.push_back(mk(1, 3'b111, 5, 6, 7, 'h100, 'h101, 'h102, 0, 0, 0, 0, 3'b001, 1, 1, 0));
        tbl.push_back(mk(1, 3'b111, 5, 6, 7, 'h100, 'h101, 'h102, 0, 0, 0, 0, 3'b010, 1, 1, 0));
        tbl.push_back(mk(1, 3'b111, 5, 6, 7, 'h100, 'h101, 'h102, 0, 0, 0, 0, 3'b100, 1, 1, 0));
        tbl.push_back(mk(1, 3'b111, 5, 6, 7, 'h100, 'h101, 'h102, 0, 0, 0, 0, 3'b001, 1, 1, 0));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0));
        tbl.push_back(mk(1, 3'b001, 0, 0, 0, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 3'b001, 1, 1, 0));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 31, 0, 0, 1, 0, 0, 0, 0, 3'b100, 1, 1, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 31, 0, 0, 2, 0, 0, 0, 0, 3'b100, 1, 1, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 31, 0, 0, 3, 0, 0, 0, 0, 3'b100, 1, 1, 0));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0));
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("v%0d", i));

        // RAW stall on r9 until the cycle after MEM commits it (pointer is 2 here).
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 3'b000, 1, 1, 32'h0), "raw_issue");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 3'b000, 0, 1, 32'h200), "raw_stall0");
        step(mk(1, 3'b010, 0, 9, 0, 0, 'h99, 0, 1, 0, 9, 0, 3'b010, 0, 1, 32'h200), "raw_memwr");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 3'b000, 0, 1, 32'h200), "raw_commit");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 3'b000, 1, 1, 32'h0), "raw_clean");

        // Issue of rd=4 on the same edge as the write of r4: set wins.
        step(mk(1, 3'b001, 4, 0, 0, 'h44, 0, 0, 0, 0, 0, 0, 3'b001, 1, 1, 32'h0), "same_alu");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 3'b000, 1, 1, 32'h0), "same_issue");
        step(mk(1, 3'b010, 0, 4, 0, 0, 'h55, 0, 1, 8, 0, 0, 3'b010, 1, 1, 32'h10), "same_set");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 3'b000, 1, 1, 32'h110), "fill9");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 3'b000, 1, 1, 32'h300), "fill10");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 3'b000, 1, 1, 32'h700), "fill11");

        // Reset with busy=0xF00 and FPU mid-handshake; ALU must win first afterwards.
        step(mk(0, 3'b100, 0, 0, 3, 0, 0, 'h33, 0, 0, 0, 0, 3'b000, 0, 1, 32'hF00), "rst_mid");
        step(mk(1, 3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 0, 0, 0, 3'b001, 1, 1, 32'h0), "rst_alu");
        step(mk(1, 3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 0, 0, 0, 3'b010, 1, 1, 32'h0), "rst_mem");
        step(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 32'h0), "drain");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
